// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: decode handoff record, fetch FSM states and
// instruction size.
package rv32i_types;

  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO holding {pc, inst} pairs between imem and decode.
// A synchronous clear overrides any push or pop in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: single-outstanding imem reads, prefetch FIFO,
// redirect squash. Define IF_PERF_CNT_EN to add fetched/dropped counters.
module if_fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  output logic [3:0]                 imem_rmask,
  input  logic [31:0]                imem_rdata,
  input  logic                       imem_resp,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       id_stall,
  output logic [$bits(if_id_t)-1:0]  if_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_dropped
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic [31:0]      req_pc_inc;
  logic [31:0]      issue_pc;
  logic             kept_resp;
  logic             push;
  logic             pop;
  logic             room;
  logic             issue;
  logic             out_valid;
  logic             show_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [63:0]      fifo_head;
  if_id_t           if_id_s;
  logic             redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign kept_resp  = (state == WAIT) && imem_resp && !redirect_valid;
  assign push       = kept_resp;
  assign out_valid  = !rst && !fifo_empty && !redirect_valid;
  assign pop        = out_valid && !id_stall;
  assign req_pc_inc = req_pc + 32'(INST_BYTES);
  assign issue_pc   = kept_resp ? req_pc_inc : fetch_pc;

  // Room is judged against the occupancy left after this cycle's push and pop.
  assign room = pop  ? (!push || !fifo_full)
              : push ? (fifo_count < CNT_W'(DEPTH - 1))
              :        !fifo_full;

  assign issue      = !rst && !redirect_valid && room &&
                      ((state == IDLE) || kept_resp);
  assign imem_addr  = issue ? issue_pc : fetch_pc;
  assign imem_rmask = issue ? 4'hf : 4'h0;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (issue) state_next = WAIT;
      WAIT: begin
        if (redirect_valid)  state_next = imem_resp ? IDLE : WAIT_DROP;
        else if (imem_resp)  state_next = issue ? WAIT : IDLE;
      end
      WAIT_DROP: if (imem_resp) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid)  fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (kept_resp)  fetch_pc <= req_pc_inc;
      if (issue) req_pc <= issue_pc;
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({req_pc, imem_rdata}),
    .pop       (pop),
    .clear     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign show_head     = !rst && !fifo_empty;
  assign if_id_s.valid = out_valid;
  assign if_id_s.pc    = show_head ? fifo_head[63:32] : 32'h0;
  assign if_id_s.inst  = show_head ? fifo_head[31:0]  : 32'h0;
  assign if_id         = if_id_s;

`ifdef IF_PERF_CNT_EN
  logic drop_resp;

  assign drop_resp = imem_resp &&
                     ((state == WAIT_DROP) || ((state == WAIT) && redirect_valid));

  // Dropped work counts discarded responses plus entries squashed by a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_dropped <= 32'h0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_dropped <= perf_dropped + 32'(drop_resp) +
                      (redirect_valid ? 32'(fifo_count) : 32'h0);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected imem requests and decode
// transfers are queued per scenario and checked by an independent monitor.
module tb_if_fetch_stage;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp  = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  if_id_t      if_id;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int compared = 0;
  int failed   = 0;

  int          mem_lat    = 1;
  logic        keep_stray = 1'b0;
  int          cyc        = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  logic [31:0] exp_req[$];
  logic [31:0] exp_out[$];

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_id          (if_id)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns addi x0,x0,imm with imm taken from the low address bits.
  function automatic logic [31:0] instFor(input logic [31:0] a);
    return {a[11:0], 20'h00013};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rv,
                               input logic [31:0] rp);
    rst            = r;
    id_stall       = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic startPhase(input int lat);
    mem_lat    = lat;
    keep_stray = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, "_req_left"}, 32'(exp_req.size()), 32'h0);
    checkOutput({name, "_out_left"}, 32'(exp_out.size()), 32'h0);
    exp_req.delete();
    exp_out.delete();
  endtask

  // Memory model: requests seen at an edge are answered mem_lat cycles later.
  always @(posedge clk) begin : memory_model
    logic        req_now;
    logic [31:0] addr_now;
    logic        rst_now;
    req_now  = (imem_rmask != 4'h0);
    addr_now = imem_addr;
    rst_now  = rst;
    #1;
    cyc = cyc + 1;
    if (rst_now && !keep_stray) begin
      pend_addr.delete();
      pend_due.delete();
    end
    if (req_now) begin
      pend_addr.push_back(addr_now);
      pend_due.push_back(cyc - 1 + mem_lat);
    end
    imem_resp  = 1'b0;
    imem_rdata = 32'h0;
    if (pend_addr.size() > 0 && pend_due[0] == cyc) begin
      imem_resp  = 1'b1;
      imem_rdata = instFor(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  end

  // Monitor: every request and every accepted decode transfer is matched
  // against the head of its expectation queue.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (imem_rmask != 4'h0) begin
      if (exp_req.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL req_extra: got request at %h, expected none", imem_addr);
      end else begin
        e = exp_req.pop_front();
        checkOutput("req_addr", imem_addr, e);
        checkOutput("req_mask", {28'h0, imem_rmask}, 32'hf);
      end
    end
    if (if_id.valid && !id_stall) begin
      if (exp_out.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL out_extra: got pc %h, expected no transfer", if_id.pc);
      end else begin
        e = exp_out.pop_front();
        checkOutput("out_pc", if_id.pc, e);
        checkOutput("out_inst", if_id.inst, instFor(e));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rmask", {28'h0, imem_rmask}, 32'h0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_valid", {31'h0, if_id.valid}, 32'h0);
    checkOutput("rst_pc", if_id.pc, 32'h0);
    checkOutput("rst_inst", if_id.inst, 32'h0);
    @(posedge clk);
    #1;

    // Streaming: one request per cycle, decode sees pcs two cycles behind.
    $display("[TB] streaming with 1-cycle memory");
    mem_lat = 1;
    for (int k = 0; k < 8; k++) exp_req.push_back(RESET_PC + 32'(4 * k));
    for (int k = 0; k < 6; k++) exp_out.push_back(RESET_PC + 32'(4 * k));
    idle(8);
    checkDrained("stream");

    // Decode stall: two entries fill the FIFO, then no requests until release.
    $display("[TB] decode stall for 6 cycles");
    startPhase(1);
    exp_req.push_back(32'h1eceb000);
    exp_req.push_back(32'h1eceb004);
    for (int k = 2; k < 8; k++) exp_req.push_back(RESET_PC + 32'(4 * k));
    for (int k = 0; k < 6; k++) exp_out.push_back(RESET_PC + 32'(4 * k));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    idle(6);
    checkDrained("stall");

    // Redirect with a request outstanding; its late response must vanish.
    $display("[TB] redirect while outstanding, 3-cycle memory");
    startPhase(3);
    exp_req.push_back(32'h1eceb000);
    exp_req.push_back(32'h1eceb100);
    exp_req.push_back(32'h1eceb104);
    exp_req.push_back(32'h1eceb108);
    exp_out.push_back(32'h1eceb100);
    exp_out.push_back(32'h1eceb104);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1eceb101);
    idle(10);
    checkDrained("redir_drop");

    // Redirect in the same cycle as the response.
    $display("[TB] redirect coincident with response");
    startPhase(2);
    exp_req.push_back(32'h1eceb000);
    exp_req.push_back(32'h1eceb200);
    exp_req.push_back(32'h1eceb204);
    exp_req.push_back(32'h1eceb208);
    exp_out.push_back(32'h1eceb200);
    exp_out.push_back(32'h1eceb204);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1eceb200);
    idle(6);
    checkDrained("redir_same");

    // One-cycle reset mid-request; the stray response lands while IDLE.
    $display("[TB] reset mid-request with stray response");
    startPhase(2);
    exp_req.push_back(32'h1eceb000);
    exp_req.push_back(32'h1eceb000);
    exp_req.push_back(32'h1eceb004);
    exp_req.push_back(32'h1eceb008);
    exp_out.push_back(32'h1eceb000);
    exp_out.push_back(32'h1eceb004);
    idle(1);
    keep_stray = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    idle(6);
    keep_stray = 1'b0;
    checkDrained("stray");

    // Redirect to the top of the address space; fetch wraps to zero.
    $display("[TB] redirect to fffffffc and wrap");
    startPhase(1);
    exp_req.push_back(32'h1eceb000);
    exp_req.push_back(32'hfffffffc);
    exp_req.push_back(32'h00000000);
    exp_req.push_back(32'h00000004);
    exp_req.push_back(32'h00000008);
    exp_out.push_back(32'hfffffffc);
    exp_out.push_back(32'h00000000);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hfffffffc);
    idle(4);
`ifdef IF_PERF_CNT_EN
    checkOutput("perf_fetched", perf_fetched, 32'd3);
    checkOutput("perf_dropped", perf_dropped, 32'd1);
`endif
    checkDrained("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
